// File: rtl/sirv_gnrl_credit_tx_if.sv
// Link bundle for the credit-based transmitter: upstream valid/ready beat, outgoing
// unstalled beat, credit return and status.
interface sirv_gnrl_credit_tx_if #(
    parameter int DW    = 32,
    parameter int CNT_W = 3
);
    logic             i_vld;
    logic             i_rdy;
    logic [DW-1:0]    i_dat;
    logic             o_vld;
    logic [DW-1:0]    o_dat;
    logic             crd_rtn;
    logic [CNT_W-1:0] crd_cnt;
    logic             idle;
    logic             crd_err;

    // Transmitter side.
    modport master (
        input  i_vld, i_dat, crd_rtn,
        output i_rdy, o_vld, o_dat, crd_cnt, idle, crd_err
    );

    // Producer/consumer side that drives the transmitter.
    modport slave (
        output i_vld, i_dat, crd_rtn,
        input  i_rdy, o_vld, o_dat, crd_cnt, idle, crd_err
    );
endinterface

// File: rtl/sirv_gnrl_credit_tx.sv
// Transmit end of a credit-based link: spends one credit per registered beat and
// regains one per crd_rtn pulse, so no ready signal has to cross the link.
module sirv_gnrl_credit_tx #(
    parameter int CREDITS = 4,
    parameter int CNT_W   = 3,
    parameter int DW      = 32,
    parameter int BYP_RTN = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    sirv_gnrl_credit_tx_if.master  lnk
);
    localparam logic [CNT_W-1:0] CRD_FULL = CNT_W'(CREDITS);
    localparam logic             BYP      = (BYP_RTN != 0);

    logic [CNT_W-1:0] crd_cnt_q, crd_cnt_d;
    logic             crd_err_q, crd_err_d;
    logic             o_vld_q;
    logic [DW-1:0]    o_dat_q;
    logic             has_crd;
    logic             rdy;
    logic             send;

    assign has_crd = (crd_cnt_q != '0);
    // With bypass, a credit coming home this cycle is spent immediately.
    assign rdy     = has_crd | (BYP & lnk.crd_rtn);
    assign send    = lnk.i_vld & rdy;

    always_comb begin
        // NOTE: defaults first so every path assigns every output -- no latches.
        crd_cnt_d = crd_cnt_q;
        crd_err_d = crd_err_q;
        if (send && !lnk.crd_rtn) begin
            crd_cnt_d = crd_cnt_q - 1'b1;
        end else if (!send && lnk.crd_rtn) begin
            if (crd_cnt_q == CRD_FULL) begin
                crd_err_d = 1'b1;
            end else begin
                crd_cnt_d = crd_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crd_cnt_q <= CRD_FULL;
            crd_err_q <= 1'b0;
            o_vld_q   <= 1'b0;
            o_dat_q   <= '0;
        end else begin
            crd_cnt_q <= crd_cnt_d;
            crd_err_q <= crd_err_d;
            o_vld_q   <= send;
            if (send) begin
                o_dat_q <= lnk.i_dat;
            end
        end
    end

    assign lnk.i_rdy   = rdy;
    assign lnk.o_vld   = o_vld_q;
    assign lnk.o_dat   = o_dat_q;
    assign lnk.crd_cnt = crd_cnt_q;
    assign lnk.crd_err = crd_err_q;
    assign lnk.idle    = (crd_cnt_q == CRD_FULL) & ~o_vld_q;
endmodule

// File: tb/tb_sirv_gnrl_credit_tx.sv
// Drives a BYP_RTN=0 and a BYP_RTN=1 transmitter with identical stimulus and checks
// both every cycle against a credit-count model, plus hand-computed scenario checks.
module tb_sirv_gnrl_credit_tx;
    localparam int CREDITS = 4;
    localparam int CNT_W   = 3;
    localparam int DW      = 32;

    logic          clk;
    logic          rst;
    logic          vld;
    logic [DW-1:0] dat;
    logic          rtn;

    int total = 0;
    int bad   = 0;

    sirv_gnrl_credit_tx_if #(.DW(DW), .CNT_W(CNT_W)) if0 ();
    sirv_gnrl_credit_tx_if #(.DW(DW), .CNT_W(CNT_W)) if1 ();

    assign if0.i_vld = vld;  assign if0.i_dat = dat;  assign if0.crd_rtn = rtn;
    assign if1.i_vld = vld;  assign if1.i_dat = dat;  assign if1.crd_rtn = rtn;

    sirv_gnrl_credit_tx #(.CREDITS(CREDITS), .CNT_W(CNT_W), .DW(DW), .BYP_RTN(0)) u_dut0 (
        .clk (clk), .rst (rst), .lnk (if0.master));
    sirv_gnrl_credit_tx #(.CREDITS(CREDITS), .CNT_W(CNT_W), .DW(DW), .BYP_RTN(1)) u_dut1 (
        .clk (clk), .rst (rst), .lnk (if1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: credits held, last beat launched, sticky overflow flag.
    int            m_cnt  [2];
    logic          m_ovld [2];
    logic [DW-1:0] m_odat [2];
    logic          m_err  [2];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_cnt[k]  = CREDITS;
                m_ovld[k] = 1'b0;
                m_odat[k] = '0;
                m_err[k]  = 1'b0;
            end else begin
                automatic bit can  = (m_cnt[k] > 0) || (k == 1 && rtn);
                automatic bit sent = vld && can;
                automatic int nxt  = m_cnt[k] + int'(rtn) - int'(sent);
                if (nxt > CREDITS) begin
                    nxt      = CREDITS;
                    m_err[k] = 1'b1;
                end
                m_cnt[k]  = nxt;
                m_ovld[k] = sent;
                if (sent) m_odat[k] = dat;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    wire [1:0]       d_rdy  = {if1.i_rdy, if0.i_rdy};
    wire [1:0]       d_ovld = {if1.o_vld, if0.o_vld};
    wire [1:0]       d_idle = {if1.idle, if0.idle};
    wire [1:0]       d_err  = {if1.crd_err, if0.crd_err};
    wire [DW-1:0]    d_odat [2];
    wire [CNT_W-1:0] d_cnt  [2];
    assign d_odat[0] = if0.o_dat;   assign d_odat[1] = if1.o_dat;
    assign d_cnt[0]  = if0.crd_cnt; assign d_cnt[1]  = if1.crd_cnt;

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("cyc_rdy%0d", k),  64'(d_rdy[k]),
                      64'((m_cnt[k] > 0) || (k == 1 && rtn)));
                check($sformatf("cyc_ovld%0d", k), 64'(d_ovld[k]), 64'(m_ovld[k]));
                check($sformatf("cyc_odat%0d", k), 64'(d_odat[k]), 64'(m_odat[k]));
                check($sformatf("cyc_cnt%0d", k),  64'(d_cnt[k]),  64'(m_cnt[k]));
                check($sformatf("cyc_err%0d", k),  64'(d_err[k]),  64'(m_err[k]));
                check($sformatf("cyc_idle%0d", k), 64'(d_idle[k]),
                      64'(m_cnt[k] == CREDITS && !m_ovld[k]));
            end
        end
    end

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        vld = v; dat = d; rtn = r;
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [DW-1:0] seen[$];
    int pulses;

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        repeat (3) tick();
        rst = 1'b0;
        check("rst_cnt",  64'(if0.crd_cnt), 64'd4);
        check("rst_idle", 64'(if0.idle),    64'd1);
        check("rst_ovld", 64'(if0.o_vld),   64'd0);
        check("rst_odat", 64'(if0.o_dat),   64'd0);
        check("rst_err",  64'(if0.crd_err), 64'd0);

        // Drain all credits with a continuous stream.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, DW'(32'h10 + k), 1'b0);
            tick();
            if (if0.o_vld) seen.push_back(if0.o_dat);
        end
        check("drain_pulses", 64'(seen.size()), 64'd4);
        for (int i = 0; i < seen.size(); i++)
            check($sformatf("drain_dat%0d", i), 64'(seen[i]), 64'(32'h10 + i));
        check("drain_cnt",  64'(if0.crd_cnt), 64'd0);
        check("drain_rdy",  64'(if0.i_rdy),   64'd0);
        check("drain_idle", 64'(if0.idle),    64'd0);

        // Single credit return while empty: blocked without bypass, spent with it.
        drive(1'b1, 32'h20, 1'b1);
        #1;
        check("empty_rdy_nobyp", 64'(if0.i_rdy), 64'd0);
        check("empty_rdy_byp",   64'(if1.i_rdy), 64'd1);
        tick();
        check("ret_cnt_nobyp",  64'(if0.crd_cnt), 64'd1);
        check("ret_ovld_nobyp", 64'(if0.o_vld),   64'd0);
        check("ret_ovld_byp",   64'(if1.o_vld),   64'd1);
        check("ret_odat_byp",   64'(if1.o_dat),   64'h20);
        check("ret_cnt_byp",    64'(if1.crd_cnt), 64'd0);
        drive(1'b1, 32'h21, 1'b0);
        #1;
        check("late_rdy_nobyp", 64'(if0.i_rdy), 64'd1);
        tick();
        check("late_ovld_nobyp", 64'(if0.o_vld),   64'd1);
        check("late_odat_nobyp", 64'(if0.o_dat),   64'h21);
        check("late_cnt_nobyp",  64'(if0.crd_cnt), 64'd0);
        check("late_ovld_byp",   64'(if1.o_vld),   64'd0);

        // Two credits home, then send and return every cycle.
        drive(1'b0, '0, 1'b1);
        tick();
        tick();
        check("two_cnt", 64'(if0.crd_cnt), 64'd2);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, DW'(32'h30 + k), 1'b1);
            tick();
            if (if0.o_vld) pulses++;
        end
        check("steady_pulses", 64'(pulses),       64'd10);
        check("steady_cnt",    64'(if0.crd_cnt),  64'd2);
        check("steady_err",    64'(if0.crd_err),  64'd0);
        check("steady_odat",   64'(if0.o_dat),    64'h39);

        // Refill, then overflow by one.
        drive(1'b0, '0, 1'b1);
        tick();
        tick();
        check("full_cnt", 64'(if0.crd_cnt), 64'd4);
        check("full_err", 64'(if0.crd_err), 64'd0);
        tick();
        check("ovf_cnt", 64'(if0.crd_cnt), 64'd4);
        check("ovf_err", 64'(if0.crd_err), 64'd1);
        drive(1'b0, '0, 1'b0);
        repeat (3) tick();
        check("ovf_sticky", 64'(if0.crd_err), 64'd1);
        check("ovf_rdy",    64'(if0.i_rdy),   64'd1);
        check("ovf_idle",   64'(if0.idle),    64'd1);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 2) == 0));
            tick();
        end

        // Reset asserted mid-operation.
        drive(1'b0, '0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, DW'(32'h40 + k), 1'b0);
            tick();
        end
        check("pre_rst_cnt",  64'(if0.crd_cnt), 64'd1);
        check("pre_rst_ovld", 64'(if0.o_vld),   64'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_ovld0", 64'(if0.o_vld),   64'd0);
        check("arst_cnt0",  64'(if0.crd_cnt), 64'd4);
        check("arst_err0",  64'(if0.crd_err), 64'd0);
        check("arst_idle0", 64'(if0.idle),    64'd1);
        check("arst_ovld1", 64'(if1.o_vld),   64'd0);
        check("arst_cnt1",  64'(if1.crd_cnt), 64'd4);
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h55, 1'b0);
        tick();
        check("post_rst_ovld", 64'(if0.o_vld),   64'd1);
        check("post_rst_odat", 64'(if0.o_dat),   64'h55);
        check("post_rst_cnt",  64'(if0.crd_cnt), 64'd3);
        drive(1'b0, '0, 1'b0);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
